// File: rtl/summ_pkg.sv
// Shared types and width helpers for the apodized channel summer.
package summ_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DRAIN = 2'd2,
    HOLD  = 2'd3
  } summ_state_e;

  // Signed sample times zero-extended unsigned weight needs one extra bit.
  function automatic int prod_width(input int data_width, input int weight_width);
    return data_width + weight_width + 1;
  endfunction

  function automatic int sum_width(input int data_width, input int weight_width,
                                   input int num_channels);
    return data_width + weight_width + 1 + $clog2(num_channels);
  endfunction

endpackage

// File: rtl/apod_mult.sv
// Registered signed-sample x unsigned-weight multiplier with a valid flag, one-cycle latency.
module apod_mult
  import summ_pkg::*;
#(
  parameter int DATA_WIDTH   = 16,
  parameter int WEIGHT_WIDTH = 8,
  parameter int PROD_WIDTH   = prod_width(DATA_WIDTH, WEIGHT_WIDTH)
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic                         clr_i,
  input  logic                         en_i,
  input  logic signed [DATA_WIDTH-1:0] sample_i,
  input  logic [WEIGHT_WIDTH-1:0]      weight_i,
  output logic signed [PROD_WIDTH-1:0] prod_o,
  output logic                         vld_o
);

  logic signed [PROD_WIDTH-1:0] sample_ext;
  logic signed [PROD_WIDTH-1:0] weight_ext;
  logic signed [PROD_WIDTH-1:0] prod_d;
  logic signed [PROD_WIDTH-1:0] prod_q;
  logic                         vld_q;

  always_comb begin
    sample_ext = PROD_WIDTH'(sample_i);
    weight_ext = PROD_WIDTH'({1'b0, weight_i});
    prod_d     = sample_ext * weight_ext;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      prod_q <= '0;
      vld_q  <= 1'b0;
    end else if (clr_i) begin
      prod_q <= '0;
      vld_q  <= 1'b0;
    end else begin
      vld_q <= en_i;
      if (en_i) begin
        prod_q <= prod_d;
      end
    end
  end

  assign prod_o = prod_q;
  assign vld_o  = vld_q;

endmodule

// File: rtl/summ_apod.sv
// Apodized delay-and-sum: weights NUM_CHANNELS beats and sums them into one result.
// Build macro SUMM_APOD_SAT_EN selects clamping of the result instead of wrapping.
module summ_apod
  import summ_pkg::*;
#(
  parameter int DATA_WIDTH   = 16,
  parameter int NUM_CHANNELS = 4,
  parameter int WEIGHT_WIDTH = 8,
  parameter int OUT_WIDTH    = 20
) (
  input  logic                              clk,
  input  logic                              reset_n,
  input  logic                              start,
  input  logic                              in_valid,
  output logic                              in_ready,
  input  logic signed [DATA_WIDTH-1:0]      in_sample,
  input  logic [WEIGHT_WIDTH-1:0]           in_weight,
  output logic                              out_valid,
  input  logic                              out_ready,
  output logic signed [OUT_WIDTH-1:0]       out_sum,
  output logic                              out_sat,
  output logic [$clog2(NUM_CHANNELS)-1:0]   chan_idx,
  output logic [1:0]                        dbg_state
);

  localparam int PROD_WIDTH = prod_width(DATA_WIDTH, WEIGHT_WIDTH);
  localparam int SUM_WIDTH  = sum_width(DATA_WIDTH, WEIGHT_WIDTH, NUM_CHANNELS);
  localparam int CW         = $clog2(NUM_CHANNELS);
  localparam logic [CW-1:0] LAST_IDX = CW'(NUM_CHANNELS - 1);

  summ_state_e                  state_q;
  logic                         in_ready_q;
  logic                         out_valid_q;
  logic signed [OUT_WIDTH-1:0]  out_sum_q;
  logic                         out_sat_q;
  logic [CW-1:0]                chan_q;
  logic signed [SUM_WIDTH-1:0]  acc_q;
  logic signed [SUM_WIDTH-1:0]  acc_d;
  logic signed [OUT_WIDTH-1:0]  res_d;
  logic                         sat_d;
  logic signed [PROD_WIDTH-1:0] prod;
  logic                         prod_vld;
  logic                         hs;
  logic                         mult_clr;
  logic                         mult_en;

  // A beat transfers on any rising edge where in_valid && in_ready; a result
  // transfers where out_valid && out_ready. Both ready/valid are level signals.
  assign hs       = in_valid && in_ready_q;
  assign mult_clr = start && (state_q != HOLD);
  assign mult_en  = hs && !start;

  apod_mult #(
    .DATA_WIDTH  (DATA_WIDTH),
    .WEIGHT_WIDTH(WEIGHT_WIDTH),
    .PROD_WIDTH  (PROD_WIDTH)
  ) u_mult (
    .clk     (clk),
    .reset_n (reset_n),
    .clr_i   (mult_clr),
    .en_i    (mult_en),
    .sample_i(in_sample),
    .weight_i(in_weight),
    .prod_o  (prod),
    .vld_o   (prod_vld)
  );

  always_comb begin
    acc_d = acc_q;
    if (prod_vld) begin
      acc_d = acc_q + SUM_WIDTH'(prod);
    end
  end

`ifdef SUMM_APOD_SAT_EN
  logic [SUM_WIDTH-OUT_WIDTH:0] hi_bits;

  // The result fits when every bit above the output sign bit matches it.
  always_comb begin
    hi_bits = acc_d[SUM_WIDTH-1:OUT_WIDTH-1];
    res_d   = OUT_WIDTH'(acc_d);
    sat_d   = 1'b0;
    if (!((&hi_bits) || !(|hi_bits))) begin
      sat_d = 1'b1;
      if (acc_d[SUM_WIDTH-1]) begin
        res_d = {1'b1, {(OUT_WIDTH-1){1'b0}}};
      end else begin
        res_d = {1'b0, {(OUT_WIDTH-1){1'b1}}};
      end
    end
  end
`else
  always_comb begin
    res_d = OUT_WIDTH'(acc_d);
    sat_d = 1'b0;
  end
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      out_sum_q   <= '0;
      out_sat_q   <= 1'b0;
      chan_q      <= '0;
      acc_q       <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            state_q    <= ACCUM;
            in_ready_q <= 1'b1;
            acc_q      <= '0;
            chan_q     <= '0;
          end
        end
        ACCUM: begin
          if (start) begin
            acc_q  <= '0;
            chan_q <= '0;
          end else begin
            acc_q <= acc_d;
            if (hs) begin
              if (chan_q == LAST_IDX) begin
                chan_q     <= '0;
                state_q    <= DRAIN;
                in_ready_q <= 1'b0;
              end else begin
                chan_q <= chan_q + 1'b1;
              end
            end
          end
        end
        DRAIN: begin
          if (start) begin
            state_q    <= ACCUM;
            in_ready_q <= 1'b1;
            acc_q      <= '0;
            chan_q     <= '0;
          end else begin
            acc_q       <= acc_d;
            out_sum_q   <= res_d;
            out_sat_q   <= sat_d;
            out_valid_q <= 1'b1;
            state_q     <= HOLD;
          end
        end
        HOLD: begin
          // start is deliberately ignored until the held result is taken.
          if (out_ready) begin
            out_valid_q <= 1'b0;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_sum   = out_sum_q;
  assign out_sat   = out_sat_q;
  assign chan_idx  = chan_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_summ_apod.sv
// Scoreboard bench for summ_apod: directed vectors, abort/reset cases and random sums.
module tb_summ_apod;

  localparam int DW = 16;
  localparam int WW = 8;
  localparam int NC = 4;
  localparam int OW = 20;
  localparam int W  = OW + 1;

  logic                 clk;
  logic                 reset_n;
  logic                 start;
  logic                 in_valid;
  logic                 in_ready;
  logic signed [DW-1:0] in_sample;
  logic [WW-1:0]        in_weight;
  logic                 out_valid;
  logic                 out_ready;
  logic signed [OW-1:0] out_sum;
  logic                 out_sat;
  logic [1:0]           chan_idx;
  logic [1:0]           dbg_state;

  logic [W-1:0] exp_q[$];
  int checks;
  int failures;

  summ_apod #(
    .DATA_WIDTH  (DW),
    .NUM_CHANNELS(NC),
    .WEIGHT_WIDTH(WW),
    .OUT_WIDTH   (OW)
  ) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .start    (start),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_sample(in_sample),
    .in_weight(in_weight),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_sum  (out_sum),
    .out_sat  (out_sat),
    .chan_idx (chan_idx),
    .dbg_state(dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [W-1:0] pack(input logic sat, input longint v);
    logic [OW-1:0] lo;
    lo = OW'(v);
    return {sat, lo};
  endfunction

  // Reference: exact sum, then clamp or wrap into OW bits.
  function automatic logic [W-1:0] model(input longint sum);
    longint maxv;
    longint minv;
    maxv = (64'sd1 <<< (OW - 1)) - 1;
    minv = -(64'sd1 <<< (OW - 1));
`ifdef SUMM_APOD_SAT_EN
    if (sum > maxv) return pack(1'b1, maxv);
    if (sum < minv) return pack(1'b1, minv);
`endif
    return pack(1'b0, sum);
  endfunction

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic send_beat(input logic signed [DW-1:0] s, input logic [WW-1:0] w,
                           input int gap);
    int n;
    in_sample = s;
    in_weight = w;
    in_valid  = 1'b1;
    n = 0;
    while (!in_ready && n < 50) begin
      tick();
      n++;
    end
    if (!in_ready) check("beat_timeout", 32'(in_ready), 32'd1);
    tick();
    in_valid = 1'b0;
    repeat (gap) tick();
  endtask

  task automatic wait_valid();
    int n;
    n = 0;
    while (!out_valid && n < 50) begin
      tick();
      n++;
    end
    check("out_valid_timeout", 32'(out_valid), 32'd1);
  endtask

  // scoreboard monitor
  always @(negedge clk) begin
    logic [W-1:0] e;
    if (reset_n && out_valid && out_ready) begin
      check("exp_pending", 32'(exp_q.size() > 0), 32'd1);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("result", 32'({out_sat, out_sum}), 32'(e));
      end
    end
  end

  initial begin
    longint sum;
    logic signed [DW-1:0] s;
    logic [WW-1:0] w;
    checks    = 0;
    failures  = 0;
    reset_n   = 1'b0;
    start     = 1'b0;
    in_valid  = 1'b0;
    in_sample = '0;
    in_weight = '0;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_sum", 32'(out_sum), 32'd0);
    check("rst_out_sat", 32'(out_sat), 32'd0);
    check("rst_chan_idx", 32'(chan_idx), 32'd0);
    check("rst_state", 32'(dbg_state), 32'd0);
    reset_n = 1'b1;
    tick();

    // Basic sum with exact output latency.
    exp_q.push_back(pack(1'b0, 260));
    do_start();
    check("accum_in_ready", 32'(in_ready), 32'd1);
    send_beat(100, 1, 0);
    check("chan_idx_after1", 32'(chan_idx), 32'd1);
    send_beat(200, 1, 0);
    send_beat(-50, 1, 0);
    check("chan_idx_after3", 32'(chan_idx), 32'd3);
    send_beat(10, 1, 0);
    check("drain_in_ready", 32'(in_ready), 32'd0);
    check("drain_out_valid", 32'(out_valid), 32'd0);
    check("drain_chan_idx", 32'(chan_idx), 32'd0);
    tick();
    check("latency_out_valid", 32'(out_valid), 32'd1);
    tick();
    check("idle_after_take", 32'(out_valid), 32'd0);

    // Large positive sum: clamp or wrap depending on build.
`ifdef SUMM_APOD_SAT_EN
    exp_q.push_back(pack(1'b1, 524287));
`else
    exp_q.push_back(pack(1'b0, -132092));
`endif
    do_start();
    for (int i = 0; i < NC; i++) send_beat(32767, 255, 0);
    wait_valid();
    tick();

    // Gapped beats with stalled downstream; held result must be stable.
    out_ready = 1'b0;
    exp_q.push_back(pack(1'b0, -12000));
    do_start();
    for (int i = 0; i < NC; i++) send_beat(-1000, 3, 2);
    wait_valid();
    for (int i = 0; i < 5; i++) begin
      check("hold_valid", 32'(out_valid), 32'd1);
      check("hold_sum", 32'(out_sum), 32'(-12000));
      check("hold_in_ready", 32'(in_ready), 32'd0);
      if (i == 2) start = 1'b1;
      tick();
      start = 1'b0;
    end
    out_ready = 1'b1;
    tick();
    check("hold_released", 32'(out_valid), 32'd0);

    // Abort mid-accumulation: only the restarted sum is reported.
    exp_q.push_back(pack(1'b0, 56));
    do_start();
    send_beat(500, 1, 0);
    send_beat(500, 1, 0);
    do_start();
    check("abort_chan_idx", 32'(chan_idx), 32'd0);
    for (int i = 0; i < NC; i++) send_beat(7, 2, 0);
    wait_valid();
    tick();

    // Abort during DRAIN.
    exp_q.push_back(pack(1'b0, 20));
    do_start();
    for (int i = 0; i < NC; i++) send_beat(1000, 1, 0);
    do_start();
    for (int i = 0; i < NC; i++) send_beat(5, 1, 0);
    wait_valid();
    tick();

    // A pair offered together with start in IDLE is not taken.
    exp_q.push_back(pack(1'b0, 4));
    start     = 1'b1;
    in_valid  = 1'b1;
    in_sample = 1000;
    in_weight = 1;
    tick();
    start    = 1'b0;
    in_valid = 1'b0;
    check("idle_pair_chan_idx", 32'(chan_idx), 32'd0);
    for (int i = 0; i < NC; i++) send_beat(1, 1, 0);
    wait_valid();
    tick();

    // Reset during HOLD discards the held result.
    out_ready = 1'b0;
    do_start();
    for (int i = 0; i < NC; i++) send_beat(1234, 9, 0);
    wait_valid();
    reset_n = 1'b0;
    #1;
    check("hold_rst_valid", 32'(out_valid), 32'd0);
    check("hold_rst_sum", 32'(out_sum), 32'd0);
    check("hold_rst_state", 32'(dbg_state), 32'd0);
    tick();
    reset_n   = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check("post_rst_no_valid", 32'(out_valid), 32'd0);
      tick();
    end
    exp_q.push_back(pack(1'b0, -36));
    do_start();
    for (int i = 0; i < NC; i++) send_beat(-3, 3, 0);
    wait_valid();
    tick();

    // Random sums with random gaps and downstream stalls.
    for (int t = 0; t < 8; t++) begin
      out_ready = 1'b0;
      sum = 0;
      do_start();
      for (int i = 0; i < NC; i++) begin
        s = DW'($urandom_range(0, 65535));
        w = WW'($urandom_range(0, 255));
        if (t == 0) s = -32768;
        if (t == 0) w = 255;
        sum += longint'(s) * longint'(w);
        if (i == NC - 1) exp_q.push_back(model(sum));
        send_beat(s, w, $urandom_range(0, 2));
      end
      wait_valid();
      repeat ($urandom_range(0, 3)) tick();
      out_ready = 1'b1;
      tick();
    end

    repeat (5) tick();
    check("exp_q_drained", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
